counter_seq_ctrl: RTL

- Sequencer that drives the 8-bit up/down counter through programmed runs: one-shot up, one-shot down, free-running wrap, and ping-pong between two limits.
- Generates the counter's enable, direction and start-value inputs, and watches the counter's count output as feedback.
- Sits between the AXI register slave and the counter instance inside the custom counter IP.

---
 rtl/counter_ctrl_pkg.sv | 24 ++
 rtl/counter_ctrl_prescale.sv | 29 ++
 rtl/counter_seq_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter sequencer: run modes, FSM states and direction encodings.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ONESHOT_UP   = 2'd0,
        ONESHOT_DOWN = 2'd1,
        FREE_UP      = 2'd2,
        PING_PONG    = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        SETTLE = 3'd3,
        CHECK  = 3'd4,
        STEP   = 3'd5,
        WAIT   = 3'd6
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_ctrl_prescale.sv
// Loadable down-counter with a zero flag; paces the idle cycles between counter steps.
module counter_ctrl_prescale
    import counter_ctrl_pkg::*;
#(
    parameter int PS_WIDTH = 16
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                load,
    input  logic [PS_WIDTH-1:0] load_value,
    input  logic                dec,
    output logic                zero
);

    logic [PS_WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - PS_WIDTH'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run sequencer for the 8-bit up/down counter: one-shot up/down, free-running wrap and
// ping-pong between two limits, using the counter's count output as feedback.
module counter_seq_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PS_WIDTH = 16
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic [WIDTH-1:0]    lo_limit,
    input  logic [WIDTH-1:0]    hi_limit,
    input  logic [PS_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]    count_in,
    output logic                cnt_enable,
    output logic                cnt_inc_dec,
    output logic [WIDTH-1:0]    cnt_start_value,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    state_e              state_reg;
    mode_e               mode_reg;
    logic [WIDTH-1:0]    lo_reg;
    logic [WIDTH-1:0]    hi_reg;
    logic [WIDTH-1:0]    target_reg;
    logic [PS_WIDTH-1:0] prescale_reg;
    logic                dir_reg;

    logic                cnt_enable_reg;
    logic                cnt_inc_dec_reg;
    logic [WIDTH-1:0]    cnt_start_value_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                cfg_err_reg;

    logic                start_down;
    logic [WIDTH-1:0]    start_target;
    logic [WIDTH-1:0]    end_limit;
    logic [PS_WIDTH-1:0] ps_reload;
    logic                ps_zero;

    assign start_down   = (mode_e'(mode) == ONESHOT_DOWN);
    assign start_target = start_down ? hi_limit : lo_limit;
    assign end_limit    = (dir_reg == DIR_UP) ? hi_reg : lo_reg;
    // WAIT always lasts at least one cycle, so prescale=0 and prescale=1 give the same period.
    assign ps_reload    = (prescale_reg == '0) ? '0 : prescale_reg - PS_WIDTH'(1);

    counter_ctrl_prescale #(
        .PS_WIDTH (PS_WIDTH)
    ) u_prescale (
        .clk        (aclk),
        .srst       (areset),
        .load       (state_reg == STEP),
        .load_value (ps_reload),
        .dec        (state_reg == WAIT),
        .zero       (ps_zero)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg           <= IDLE;
            mode_reg            <= ONESHOT_UP;
            lo_reg              <= '0;
            hi_reg              <= '0;
            target_reg          <= '0;
            prescale_reg        <= '0;
            dir_reg             <= DIR_UP;
            cnt_enable_reg      <= 1'b0;
            cnt_inc_dec_reg     <= 1'b0;
            cnt_start_value_reg <= '0;
            busy_reg            <= 1'b0;
            done_reg            <= 1'b0;
            cfg_err_reg         <= 1'b0;
        end else begin
            cnt_enable_reg <= 1'b0;
            done_reg       <= 1'b0;
            cfg_err_reg    <= 1'b0;
            if (stop) begin
                // Abort (or veto a simultaneous start); start value is left as is.
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            if (lo_limit > hi_limit) begin
                                cfg_err_reg <= 1'b1;
                            end else begin
                                mode_reg            <= mode_e'(mode);
                                lo_reg              <= lo_limit;
                                hi_reg              <= hi_limit;
                                prescale_reg        <= prescale;
                                target_reg          <= start_target;
                                dir_reg             <= start_down ? DIR_DOWN : DIR_UP;
                                cnt_start_value_reg <= ~start_target;
                                busy_reg            <= 1'b1;
                                state_reg           <= LOAD_A;
                            end
                        end
                    end
                    // Complement then true value forces the counter to see a change and reload.
                    LOAD_A: begin
                        cnt_start_value_reg <= target_reg;
                        state_reg           <= LOAD_B;
                    end
                    LOAD_B: state_reg <= SETTLE;
                    SETTLE: state_reg <= CHECK;
                    CHECK: begin
                        if (count_in != end_limit) begin
                            cnt_enable_reg  <= 1'b1;
                            cnt_inc_dec_reg <= dir_reg;
                            state_reg       <= STEP;
                        end else begin
                            case (mode_reg)
                                ONESHOT_UP, ONESHOT_DOWN: begin
                                    done_reg  <= 1'b1;
                                    busy_reg  <= 1'b0;
                                    state_reg <= IDLE;
                                end
                                FREE_UP: begin
                                    cnt_start_value_reg <= ~target_reg;
                                    state_reg           <= LOAD_A;
                                end
                                PING_PONG: begin
                                    // With lo==hi there is nowhere to go: hold in CHECK until stop.
                                    if (lo_reg != hi_reg) begin
                                        dir_reg         <= ~dir_reg;
                                        cnt_enable_reg  <= 1'b1;
                                        cnt_inc_dec_reg <= ~dir_reg;
                                        state_reg       <= STEP;
                                    end
                                end
                                default: state_reg <= IDLE;
                            endcase
                        end
                    end
                    STEP: state_reg <= WAIT;
                    WAIT: begin
                        if (ps_zero) begin
                            state_reg <= CHECK;
                        end
                    end
                    default: begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cnt_enable      = cnt_enable_reg;
    assign cnt_inc_dec     = cnt_inc_dec_reg;
    assign cnt_start_value = cnt_start_value_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign cfg_err         = cfg_err_reg;

endmodule
